// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose: fetch FSM state encoding, instruction width, default reset PC and the
//          NOP word (addi x0,x0,0) presented to ID when no instruction is held.
package if_stage_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] PC_RESET_DEF  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // IDLE   : nothing outstanding
    // BUSY   : one request outstanding, response will be consumed
    // KILLED : one request outstanding, response will be discarded
    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_BUSY   = 2'd1,
        FETCH_KILLED = 2'd2
    } fetch_state_e;

    // Word-align an address by clearing the byte offset.
    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry {pc, instr} holding buffer for responses arriving during stall
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_i              capture pc_i/instr_i (response arrived while IF/ID is stalled)
//   drain_i             entry has been moved into IF/ID, mark empty
//   clear_i             flush on redirect (wins over load and drain)
//   pc_i, instr_i       entry to capture
//   full_o, pc_o, instr_o  buffer status and held entry
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] pc_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               full_q,  full_d;
    logic [INSTR_W-1:0] pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// Purpose: holds the PC, fetches words over a req/gnt/rvalid handshake with at most
//          one request outstanding, and presents {pc, pc+4, instr, decoder slices} to ID.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   stall_i                           hold IF/ID, issue no new fetch
//   redirect_i, redirect_pc_i         flush and refetch from target (bits [1:0] ignored)
//   imem_req_o, imem_addr_o           fetch request and word address
//   imem_gnt_i                        request accepted this cycle
//   imem_rvalid_i, imem_rdata_i       fetch response
//   ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o   IF/ID register contents
//   op_o, funct3_o, funct7_o          decoder slices of ifid_instr_o
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [INSTR_W-1:0] redirect_pc_i,
    output logic               imem_req_o,
    output logic [INSTR_W-1:0] imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [6:0]         op_o,
    output logic [2:0]         funct3_o,
    output logic [6:0]         funct7_o
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;

    logic               req;
    logic               fire;
    logic               resp_use;
    logic               skid_full;
    logic               skid_load;
    logic               skid_drain;
    logic [INSTR_W-1:0] skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    // A BUSY slot frees in the same cycle its response arrives, which is what
    // lets back-to-back fetches sustain one instruction per cycle.
    assign req = ~rst & ~redirect_i & ~stall_i & ~skid_full &
                 ((state_q == FETCH_IDLE) ||
                  ((state_q == FETCH_BUSY) && imem_rvalid_i));
    assign fire     = req & imem_gnt_i;
    assign resp_use = (state_q == FETCH_BUSY) & imem_rvalid_i & ~redirect_i;

    assign skid_load  = resp_use & stall_i;
    assign skid_drain = skid_full & ~stall_i & ~redirect_i;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (redirect_i),
        .pc_i    (inflight_pc_q),
        .instr_i (imem_rdata_i),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        state_d       = state_q;

        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (fire) begin
            inflight_pc_d = pc_q;
        end

        case (state_q)
            FETCH_IDLE: begin
                if (fire) state_d = FETCH_BUSY;
            end
            FETCH_BUSY: begin
                if (redirect_i) begin
                    // A response landing in the redirect cycle is simply dropped.
                    state_d = imem_rvalid_i ? FETCH_IDLE : FETCH_KILLED;
                end else if (imem_rvalid_i) begin
                    state_d = fire ? FETCH_BUSY : FETCH_IDLE;
                end
            end
            FETCH_KILLED: begin
                if (imem_rvalid_i) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (redirect_i) begin
            ifid_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (skid_full) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc;
                ifid_instr_d = skid_instr;
            end else if (resp_use) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = inflight_pc_q;
                ifid_instr_d = imem_rdata_i;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= PC_RESET;
            inflight_pc_q <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_pc_q     <= '0;
            ifid_instr_q  <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc_q + 32'd4;
    assign ifid_instr_o = ifid_valid_q ? ifid_instr_q : NOP_INSTR;
    assign op_o         = ifid_instr_o[6:0];
    assign funct3_o     = ifid_instr_o[14:12];
    assign funct7_o     = ifid_instr_o[31:25];

endmodule
